// File: rtl/slice_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slice_sched_pkg
//  Description : Shared definitions for the three-slice RAM scheduler:
//                slice count, slice-state encoding, slice-select encoding
//                and small helpers used by slice_sched and slice_ptr.
//  Revision    : 1.0  initial release
// ============================================================================
package slice_sched_pkg;

    localparam int c_NSLC = 3;

    // Per-slice lifecycle state
    typedef logic [1:0] slc_state_t;
    localparam slc_state_t c_ST_FREE     = 2'd0;
    localparam slc_state_t c_ST_FILLING  = 2'd1;
    localparam slc_state_t c_ST_FULL     = 2'd2;
    localparam slc_state_t c_ST_DRAINING = 2'd3;

    // Slice select as driven onto the RAM; 2'b11 is never used
    typedef logic [1:0] slc_sel_t;
    localparam slc_sel_t c_SLC0 = 2'b00;
    localparam slc_sel_t c_SLC1 = 2'b01;
    localparam slc_sel_t c_SLC2 = 2'b10;

    // Ring successor 0 -> 1 -> 2 -> 0
    function automatic slc_sel_t next_slc(input slc_sel_t s);
        return (s == c_SLC2) ? c_SLC0 : slc_sel_t'(s + 2'd1);
    endfunction

    // A slice may take producer words
    function automatic logic is_writable(input slc_state_t st);
        return (st == c_ST_FREE) || (st == c_ST_FILLING);
    endfunction

    // A slice holds words for the consumer
    function automatic logic is_readable(input slc_state_t st);
        return (st == c_ST_FULL) || (st == c_ST_DRAINING);
    endfunction

endpackage
`default_nettype wire

// File: rtl/slice_sched_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : slice_ptr
//  Description : Two-bit modulo-3 slice pointer; steps to the next slice
//                whenever i_adv is high.
//  Revision    : 1.0  initial release
// ============================================================================
module slice_ptr
    import slice_sched_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_adv,
    output slc_sel_t o_ptr
);

    slc_sel_t r_ptr;

    // Pointer register: reset to slice 0, advance around the ring
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= c_SLC0;
        end else if (i_adv) begin
            r_ptr <= next_slc(r_ptr);
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/slice_sched.sv
`default_nettype none
// ============================================================================
//  Module      : slice_sched
//  Description : Schedules three RAM slices as a ring buffer between a
//                producer (write side) and a consumer (read side). Each
//                slice moves FREE -> FILLING -> FULL -> DRAINING -> FREE.
//                Optional status outputs (fill, err) are built only when
//                the macro SLICE_SCHED_STATUS_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module slice_sched
    import slice_sched_pkg::*;
#(
    parameter int DEPTH = 40,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic          wr_last,
    output logic          wr_ready,
    input  logic          rd_en,
    output logic          rd_ready,
    output logic          rd_dvalid,
    output logic          rd_dlast,
    output logic          wren,
    output logic [AW-1:0] wraddr,
    output logic [1:0]    wrslc,
    output logic [AW-1:0] rdaddr,
    output logic [1:0]    rdslc,
    output logic [1:0]    fill,
    output logic          err
);

    slc_state_t    r_st  [c_NSLC];
    logic [AW-1:0] r_len [c_NSLC];
    logic [AW-1:0] r_wcnt;
    logic [AW-1:0] r_rcnt;
    logic [AW-1:0] r_rdaddr_q;
    slc_sel_t      r_rdslc_q;
    logic          r_dvalid;
    logic          r_dlast;

    slc_sel_t      w_wptr;
    slc_sel_t      w_rptr;
    logic          w_wr_ready;
    logic          w_rd_ready;
    logic [AW-1:0] w_cur_len;
    logic          w_wren;
    logic          w_wclose;
    logic          w_rd_acc;
    logic          w_rclose;

    slice_ptr u_wptr (
        .clk   (clk),
        .rst   (rst),
        .i_adv (w_wclose),
        .o_ptr (w_wptr)
    );

    slice_ptr u_rptr (
        .clk   (clk),
        .rst   (rst),
        .i_adv (w_rclose),
        .o_ptr (w_rptr)
    );

    // Handshake decode from registered slice state only
    always_comb begin
        w_wr_ready = 1'b0;
        w_rd_ready = 1'b0;
        w_cur_len  = '0;
        for (int i = 0; i < c_NSLC; i++) begin
            if (w_wptr == slc_sel_t'(i)) begin
                w_wr_ready = is_writable(r_st[i]);
            end
            if (w_rptr == slc_sel_t'(i)) begin
                w_rd_ready = is_readable(r_st[i]);
                w_cur_len  = r_len[i];
            end
        end
        w_wren   = wr_valid & w_wr_ready;
        w_wclose = w_wren & (wr_last | (r_wcnt == AW'(DEPTH - 1)));
        w_rd_acc = rd_en & w_rd_ready;
        w_rclose = w_rd_acc & (r_rcnt == (w_cur_len - AW'(1)));
    end

    // Slice state and stored length; write and read touch different slices
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NSLC; i++) begin
                r_st[i]  <= c_ST_FREE;
                r_len[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NSLC; i++) begin
                if (w_wren && (w_wptr == slc_sel_t'(i))) begin
                    r_st[i] <= w_wclose ? c_ST_FULL : c_ST_FILLING;
                    if (w_wclose) begin
                        r_len[i] <= r_wcnt + AW'(1);
                    end
                end
                if (w_rd_acc && (w_rptr == slc_sel_t'(i))) begin
                    r_st[i] <= w_rclose ? c_ST_FREE : c_ST_DRAINING;
                end
            end
        end
    end

    // Word counters within the current write and read slices
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt <= '0;
            r_rcnt <= '0;
        end else begin
            if (w_wclose) begin
                r_wcnt <= '0;
            end else if (w_wren) begin
                r_wcnt <= r_wcnt + AW'(1);
            end
            if (w_rclose) begin
                r_rcnt <= '0;
            end else if (w_rd_acc) begin
                r_rcnt <= r_rcnt + AW'(1);
            end
        end
    end

    // Read address hold and one-cycle-delayed data-valid to match RAM latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdaddr_q <= '0;
            r_rdslc_q  <= c_SLC0;
            r_dvalid   <= 1'b0;
            r_dlast    <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_rdaddr_q <= r_rcnt;
                r_rdslc_q  <= w_rptr;
            end
            r_dvalid <= w_rd_acc;
            r_dlast  <= w_rclose;
        end
    end

    assign wr_ready  = w_wr_ready;
    assign wren      = w_wren;
    assign wraddr    = r_wcnt;
    assign wrslc     = w_wptr;
    assign rd_ready  = w_rd_ready;
    assign rdaddr    = w_rd_acc ? r_rcnt : r_rdaddr_q;
    assign rdslc     = w_rd_acc ? w_rptr : r_rdslc_q;
    assign rd_dvalid = r_dvalid;
    assign rd_dlast  = r_dlast;

`ifdef SLICE_SCHED_STATUS_EN
    logic [1:0] w_fill;
    logic       r_err;

    // Count slices holding unread data
    always_comb begin
        w_fill = 2'd0;
        for (int i = 0; i < c_NSLC; i++) begin
            w_fill = w_fill + {1'b0, is_readable(r_st[i])};
        end
    end

    // Sticky protocol error: stray wr_last or read of an empty buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((wr_last & ~wr_valid) | (rd_en & ~w_rd_ready)) begin
            r_err <= 1'b1;
        end
    end

    assign fill = w_fill;
    assign err  = r_err;
`else
    assign fill = 2'd0;
    assign err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slice_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slice_sched
//  Description : Self-checking bench for slice_sched: table-driven vectors,
//                directed sequences and random traffic against a queue-based
//                reference model (status outputs follow SLICE_SCHED_STATUS_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_slice_sched;

    localparam int DEPTH = 40;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst, wr_valid, wr_last, rd_en;
    logic          wr_ready, rd_ready, rd_dvalid, rd_dlast, wren, err;
    logic [AW-1:0] wraddr, rdaddr;
    logic [1:0]    wrslc, rdslc, fill;

    slice_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_last(wr_last),
        .wr_ready(wr_ready), .rd_en(rd_en), .rd_ready(rd_ready),
        .rd_dvalid(rd_dvalid), .rd_dlast(rd_dlast), .wren(wren),
        .wraddr(wraddr), .wrslc(wrslc), .rdaddr(rdaddr), .rdslc(rdslc),
        .fill(fill), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of lengths of completed, not yet consumed slices
    int fq[$];
    int m_wcnt, m_ridx, m_wslot, m_rslot, m_hold_addr, m_hold_slc;
    bit m_dv, m_dl, m_err;

    // Observed outputs from the most recent step
    int obs_wr_ready, obs_wren, obs_wraddr, obs_wrslc, obs_rd_ready;
    int obs_rdaddr, obs_rdslc, obs_dv, obs_dl, obs_fill, obs_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        fq.delete();
        m_wcnt = 0; m_ridx = 0; m_wslot = 0; m_rslot = 0;
        m_hold_addr = 0; m_hold_slc = 0;
        m_dv = 0; m_dl = 0; m_err = 0;
    endtask

    function automatic int exp_status(input int v);
`ifdef SLICE_SCHED_STATUS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // One clock cycle: drive, check against model, clock, advance model
    task automatic step(input bit r, input bit wv, input bit wl, input bit re);
        bit wrdy, rrdy, acc_w, acc_r, nd_l;
        rst = r; wr_valid = wv; wr_last = wl; rd_en = re;
        @(negedge clk);
        obs_wr_ready = int'(wr_ready); obs_wren = int'(wren);
        obs_wraddr = int'(wraddr);     obs_wrslc = int'(wrslc);
        obs_rd_ready = int'(rd_ready); obs_rdaddr = int'(rdaddr);
        obs_rdslc = int'(rdslc);       obs_dv = int'(rd_dvalid);
        obs_dl = int'(rd_dlast);       obs_fill = int'(fill);
        obs_err = int'(err);
        wrdy  = fq.size() < 3;
        rrdy  = fq.size() > 0;
        acc_w = wv && wrdy;
        acc_r = re && rrdy;
        chk("wr_ready", obs_wr_ready, int'(wrdy));
        chk("wren", obs_wren, int'(acc_w));
        chk("wraddr", obs_wraddr, m_wcnt);
        chk("wrslc", obs_wrslc, m_wslot);
        chk("rd_ready", obs_rd_ready, int'(rrdy));
        chk("rdaddr", obs_rdaddr, acc_r ? m_ridx : m_hold_addr);
        chk("rdslc", obs_rdslc, acc_r ? m_rslot : m_hold_slc);
        chk("rd_dvalid", obs_dv, int'(m_dv));
        chk("rd_dlast", obs_dl, int'(m_dl));
        chk("fill", obs_fill, exp_status(fq.size()));
        chk("err", obs_err, exp_status(int'(m_err)));
        @(posedge clk);
        if (r) begin
            m_reset();
        end else begin
            if ((wl && !wv) || (re && !rrdy)) m_err = 1;
            nd_l = 0;
            if (acc_r) begin
                nd_l = (m_ridx == fq[0] - 1);
                m_hold_addr = m_ridx;
                m_hold_slc  = m_rslot;
                m_ridx++;
                if (m_ridx == fq[0]) begin
                    void'(fq.pop_front());
                    m_ridx  = 0;
                    m_rslot = (m_rslot + 1) % 3;
                end
            end
            m_dv = acc_r;
            m_dl = nd_l;
            if (acc_w) begin
                if (wl || m_wcnt == DEPTH - 1) begin
                    fq.push_back(m_wcnt + 1);
                    m_wcnt  = 0;
                    m_wslot = (m_wslot + 1) % 3;
                end else begin
                    m_wcnt++;
                end
            end
        end
        #1;
    endtask

    typedef struct {
        bit wv, wl, re;
        bit e_wr_ready, e_wren;
        int e_wraddr, e_wrslc;
        bit e_rd_ready;
        int e_rdaddr, e_rdslc;
        bit e_dv, e_dl;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // 3-word slice, drain, then a 1-word slice and its drain
        tbl[0] = '{1,0,0, 1,1,0,0, 0,0,0, 0,0};
        tbl[1] = '{1,0,0, 1,1,1,0, 0,0,0, 0,0};
        tbl[2] = '{1,1,0, 1,1,2,0, 0,0,0, 0,0};
        tbl[3] = '{0,0,1, 1,0,0,1, 1,0,0, 0,0};
        tbl[4] = '{0,0,1, 1,0,0,1, 1,1,0, 1,0};
        tbl[5] = '{0,0,1, 1,0,0,1, 1,2,0, 1,0};
        tbl[6] = '{0,0,0, 1,0,0,1, 0,2,0, 1,1};
        tbl[7] = '{1,1,0, 1,1,0,1, 0,2,0, 0,0};
        tbl[8] = '{0,0,1, 1,0,0,2, 1,0,1, 0,0};
        tbl[9] = '{0,0,0, 1,0,0,2, 0,0,1, 1,1};

        rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        m_reset();
        #1;

        // Reset state, then table vectors
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, tbl[i].wv, tbl[i].wl, tbl[i].re);
            chk($sformatf("tbl%0d_wr_ready", i), obs_wr_ready, int'(tbl[i].e_wr_ready));
            chk($sformatf("tbl%0d_wren", i), obs_wren, int'(tbl[i].e_wren));
            chk($sformatf("tbl%0d_wraddr", i), obs_wraddr, tbl[i].e_wraddr);
            chk($sformatf("tbl%0d_wrslc", i), obs_wrslc, tbl[i].e_wrslc);
            chk($sformatf("tbl%0d_rd_ready", i), obs_rd_ready, int'(tbl[i].e_rd_ready));
            chk($sformatf("tbl%0d_rdaddr", i), obs_rdaddr, tbl[i].e_rdaddr);
            chk($sformatf("tbl%0d_rdslc", i), obs_rdslc, tbl[i].e_rdslc);
            chk($sformatf("tbl%0d_dv", i), obs_dv, int'(tbl[i].e_dv));
            chk($sformatf("tbl%0d_dl", i), obs_dl, int'(tbl[i].e_dl));
        end

        // Full-depth slice without wr_last closes at word 40
        step(1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 0, 0);
            chk("depth_wren", obs_wren, 1);
            chk("depth_wraddr", obs_wraddr, i);
            chk("depth_wrslc", obs_wrslc, 0);
        end
        step(0, 0, 0, 0);
        chk("depth_next_wrslc", obs_wrslc, 1);
        chk("depth_rd_ready", obs_rd_ready, 1);

        // Fill remaining slices, then free one by draining slice 0
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        chk("full_wr_ready", obs_wr_ready, 0);
        chk("full_wren", obs_wren, 0);
        chk("full_fill", obs_fill, exp_status(3));
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 1);
            chk("drain_rdaddr", obs_rdaddr, i);
            if (i == DEPTH - 1) chk("drain_last_wr_ready", obs_wr_ready, 0);
        end
        step(0, 0, 0, 0);
        chk("freed_wr_ready", obs_wr_ready, 1);
        chk("freed_dlast", obs_dl, 1);

        // Concurrent write on slice 1 and read on slice 0
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, (i == 4), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, (i == 4), 1);
            chk("conc_wren", obs_wren, 1);
            chk("conc_wraddr", obs_wraddr, i);
            chk("conc_wrslc", obs_wrslc, 1);
            chk("conc_rdaddr", obs_rdaddr, i);
            chk("conc_rdslc", obs_rdslc, 0);
        end
        step(0, 0, 0, 0);
        chk("conc_dl", obs_dl, 1);

        // Reset while writing slice 2 with a read accepted in the same cycle
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 1);
        step(0, 0, 0, 0);
        chk("rst_wr_ready", obs_wr_ready, 1);
        chk("rst_rd_ready", obs_rd_ready, 0);
        chk("rst_dv", obs_dv, 0);
        chk("rst_dl", obs_dl, 0);
        chk("rst_wraddr", obs_wraddr, 0);
        chk("rst_wrslc", obs_wrslc, 0);
        chk("rst_rdaddr", obs_rdaddr, 0);
        chk("rst_rdslc", obs_rdslc, 0);
        chk("rst_fill", obs_fill, 0);
        step(0, 0, 0, 0);
        chk("rst_dv2", obs_dv, 0);

        // Read while empty: sticky error only with status enabled
        step(0, 0, 0, 1);
        chk("err_rd_ignored", obs_rd_ready, 0);
        step(0, 0, 0, 0);
        chk("err_set", obs_err, exp_status(1));
        chk("err_no_dv", obs_dv, 0);
        repeat (3) step(0, 0, 0, 0);
        chk("err_held", obs_err, exp_status(1));
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("err_cleared", obs_err, 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(199) == 0),
                 ($urandom_range(99) < 70),
                 ($urandom_range(99) < 20),
                 ($urandom_range(99) < 60));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
